fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end; the reading initiator for the synchronous-read instruction memory.
- Owns the PC and presents a word address every cycle.
- Captures the 64-bit read word one cycle later and selects the 32-bit instruction by PC[2].
- Buffers results in a small flushable queue feeding decode over a valid/ready handshake; branch/jump redirects flush all in-flight work.

Parameters:
- DEPTH, 2048: instruction memory depth in 64-bit words.
- ADDR_WIDTH, $clog2(DEPTH): memory word-address width.
- DATA_WIDTH, 64: memory word width; fixed at 64.
- XLEN, 64: PC width.
- RESET_PC, 0: byte address fetched after reset; bits [1:0] must be 0.
- QDEPTH, 4: instruction queue entries; at least 3 is required for 1 instr/cycle.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- o_mem_addr  out  ADDR_WIDTH  word address to memory, = pc[ADDR_WIDTH+2:3].
- i_mem_rdata  in  DATA_WIDTH  memory word for the address presented the previous cycle.
- o_valid  out  1  head of queue holds an instruction.
- o_instr  out  32  instruction at head.
- o_pc  out  XLEN  byte PC of o_instr.
- i_ready  in  1  decode accepts the head this cycle.
- i_redirect  in  1  flush and restart fetch.
- i_redirect_pc  in  XLEN  redirect target byte address.

Behaviour:
- Reset (rst=1 at posedge): pc<=RESET_PC, inflight<=0, queue count<=0. Next cycle o_valid=0; o_instr and o_pc are don't-care. o_mem_addr is combinational from pc. i_mem_rdata is ignored while inflight=0.
- Issue condition, from registered values: issue = !i_redirect && (count + inflight < QDEPTH).
- On issue at an edge:
  - inflight<=1; req_pc<=pc; pc<=pc+4 (modulo 2^XLEN).
  - Two consecutive issues reading the same memory word is intended; each selects a different half.
  - When not issuing: inflight<=0 and pc holds.
- Response: in the cycle after issue (inflight=1), the block pushes entry {req_pc, req_pc[2] ? rdata[63:32] : rdata[31:0]} at the next edge. The entry is visible on o_valid the following cycle.
- Latency: address presented in cycle N, data in N+1, o_valid in N+2.
- Handshake:
  - Pop when o_valid && i_ready.
  - o_instr/o_pc stay stable while o_valid && !i_ready.
  - Push and pop in the same cycle leave count unchanged.
  - The issue rule guarantees no push into a full queue; an assertion checks this.
- Steady state with QDEPTH=4 and i_ready=1: one instruction per cycle, contiguous PCs.
- Address wrap: o_mem_addr wraps modulo DEPTH because it is a bit-slice. o_pc does not wrap; it keeps the full XLEN value.
- Redirect (i_redirect=1 at an edge):
  - queue count<=0; inflight<=0, so any response arriving next cycle is discarded.
  - pc<={i_redirect_pc[XLEN-1:2],2'b00}, so low bits are ignored.
  - No issue occurs in the redirect cycle.
  - A pop in the same cycle is still a completed handshake; decode owns that instruction.
  - Target appears on o_valid no earlier than 3 cycles after the redirect edge cycle (R issue-free, R+1 issue, R+2 data, R+3 valid).
- Redirect during rst: reset wins.
- Reset mid-operation: all queue contents and in-flight responses are dropped. o_valid=0 the cycle after the reset edge. Fetch restarts at RESET_PC.
- Memory write-enables are not driven by this block; the memory's write port is tied off at the integration level.

Decomposition:
- fetch_pkg holds:
  - ILEN=32.
  - fetch_entry_t packed struct {logic [XLEN-1:0] pc; logic [31:0] instr}.
  - Function sel_half(word, pc2) returning the selected 32-bit instruction.
- Sub-module fetch_queue (parameter QDEPTH):
  - Synchronous FIFO of fetch_entry_t with push, pop, flush (flush has priority over push) and count output.
  - Pointers wrap modulo QDEPTH; count is $clog2(QDEPTH+1) bits wide.
- fetch_unit contains the PC, inflight/req_pc registers, issue logic and one fetch_queue.

Test Plan:
- Cold start: RESET_PC=0, mem[0]=64'h00500113_00200093, mem[1]=64'h002081B3_00000013, i_ready=1. Response: o_valid first high 2 cycles after the first rst-low cycle; then back-to-back (pc,instr) = (0,00200093), (4,00500113), (8,00000013), (C,002081B3).
- Backpressure: i_ready=0 for 10 cycles from start. Response: o_valid=1 with pc 0 held stable; count saturates at 4; o_mem_addr stops advancing. On release: pcs 0,4,8,C,10,14 contiguous with no gaps or duplicates.
- Redirect: i_redirect=1, i_redirect_pc=0x104 while queue holds 3 entries with one in flight. Response: o_valid=0 the next cycle; next accepted instruction is pc 0x104, instr = mem[0x20][63:32], valid 3 cycles after redirect; stale pcs never appear.
- Misaligned redirect: i_redirect_pc=0x106. Response: identical behaviour to 0x104. Also drive redirect and pop in the same cycle: the popped instruction counts once and the queue is empty afterwards.
- Mid-operation reset: rst=1 for 1 cycle with a full queue and i_ready=0. Response: o_valid=0 the next cycle; restart at RESET_PC with pc 0 first.
- Wrap: RESET_PC=DEPTH*8-4. Response: first instr = mem[DEPTH-1][63:32]; then o_mem_addr=0 and o_pc=DEPTH*8 with instr = mem[0][31:0].

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// An entry pairs a fetched instruction with the byte PC it was fetched from.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // A 64-bit memory word holds two instructions; PC bit 2 picks the half.
  function automatic logic [ILEN-1:0] sel_half(input logic [63:0] word, input logic pc2);
    return pc2 ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions between fetch and decode.
// Flush empties it at once and takes priority over a push in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int CW = $clog2(QDEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  fetch_entry_t    slots [QDEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count != '0);
  assign head   = slots[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  // The issue rule upstream reserves a slot for every in-flight read.
  assert property (@(posedge clk) disable iff (rst) (push && !flush) |-> (count != FULL));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the synchronous instruction
// memory one word per cycle and feeds decode through a flushable queue.
module fetch_unit #(
  parameter int              DEPTH      = 2048,
  parameter int              ADDR_WIDTH = $clog2(DEPTH),
  parameter int              DATA_WIDTH = 64,
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              QDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_valid,
  output logic [31:0]           o_instr,
  output logic [XLEN-1:0]       o_pc,
  input  logic                  i_ready,
  input  logic                  i_redirect,
  input  logic [XLEN-1:0]       i_redirect_pc
);

  import fetch_pkg::*;

  localparam int CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            issue;
  logic            pop;
  logic [CW-1:0]   q_count;
  logic [CW:0]     occupancy;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic            unused_redirect_bits;

  // Redirect targets are word-aligned by dropping the two low bits.
  assign unused_redirect_bits = ^i_redirect_pc[1:0];

  // A read is only started when the queue can absorb its response.
  assign occupancy = {1'b0, q_count} + (CW + 1)'(inflight);
  assign issue     = !i_redirect && (occupancy < (CW + 1)'(QDEPTH));

  assign o_mem_addr = pc[ADDR_WIDTH+2:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (i_redirect) begin
        pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
      end else if (issue) begin
        req_pc <= pc;
        pc     <= pc + XLEN'(4);
      end
    end
  end

  assign push_data = '{pc: req_pc, instr: sel_half(i_mem_rdata[63:0], req_pc[2])};

  assign o_valid = (q_count != '0);
  assign pop     = o_valid && i_ready;
  assign o_instr = head.instr;
  assign o_pc    = head.pc;

  // The flush input drops the response of a read issued before a redirect.
  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (i_redirect),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (q_count)
  );

endmodule
